// File: rtl/hilo_muldiv_unit.sv
// HI/LO register file with a multi-cycle multiply/divide engine for the EX stage.
// Stalls the pipeline while an op is in flight and pulses done when HI/LO get the result.
module hilo_muldiv_unit #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        start,
  input  logic [4:0]  alucontrol,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] hilo_rdata
);

  localparam logic [4:0] MULT_CONTROL  = 5'd16;
  localparam logic [4:0] MULTU_CONTROL = 5'd17;
  localparam logic [4:0] DIV_CONTROL   = 5'd18;
  localparam logic [4:0] DIVU_CONTROL  = 5'd19;
  localparam logic [4:0] MTHI_CONTROL  = 5'd20;
  localparam logic [4:0] MTLO_CONTROL  = 5'd21;
  localparam logic [4:0] MFHI_CONTROL  = 5'd22;
  localparam logic [4:0] MFLO_CONTROL  = 5'd23;

  // Counter must reach both MUL_LAT-1 and the 31st divide iteration.
  localparam int CNT_W = (MUL_LAT > 32) ? $clog2(MUL_LAT) : 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      op_a_q;
  logic [31:0]      op_b_q;
  logic [31:0]      rem_q;
  logic             signed_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;

  logic is_mul, is_div, accept, acc_mul, acc_div, div_zero;
  logic mul_last, div_last;

  assign is_mul   = (alucontrol == MULT_CONTROL) || (alucontrol == MULTU_CONTROL);
  assign is_div   = (alucontrol == DIV_CONTROL)  || (alucontrol == DIVU_CONTROL);
  assign accept   = (state_q == ST_IDLE) && start && !flush;
  assign acc_mul  = accept && is_mul;
  assign acc_div  = accept && is_div;
  assign div_zero = (srcb == 32'd0);
  assign mul_last = (cnt_q == CNT_W'(MUL_LAT - 1));
  assign div_last = (cnt_q == CNT_W'(31));

  // Operand magnitudes for the divider; 0x80000000 negates to itself, which is the right magnitude.
  logic        div_signed, a_neg, b_neg;
  logic [31:0] mag_a, mag_b;

  assign div_signed = (alucontrol == DIV_CONTROL);
  assign a_neg      = div_signed && srca[31];
  assign b_neg      = div_signed && srcb[31];
  assign mag_a      = a_neg ? (32'd0 - srca) : srca;
  assign mag_b      = b_neg ? (32'd0 - srcb) : srcb;

  // Multiply: sign/zero extend to 64 bits so a plain 64-bit product gives the right low half.
  logic [63:0] mul_a_ext, mul_b_ext, product;

  assign mul_a_ext = {{32{signed_q && op_a_q[31]}}, op_a_q};
  assign mul_b_ext = {{32{signed_q && op_b_q[31]}}, op_b_q};
  assign product   = mul_a_ext * mul_b_ext;

  // One restoring step: op_a_q shifts the dividend out at the top and quotient bits in at the bottom.
  logic [32:0] div_shifted;
  logic        div_ge;
  logic [31:0] rem_n, quo_n, quo_fix, rem_fix;

  assign div_shifted = {rem_q, op_a_q[31]};
  assign div_ge      = (div_shifted >= {1'b0, op_b_q});
  assign rem_n       = div_ge ? 32'(div_shifted - {1'b0, op_b_q}) : div_shifted[31:0];
  assign quo_n       = {op_a_q[30:0], div_ge};
  assign quo_fix     = neg_quo_q ? (32'd0 - quo_n) : quo_n;
  assign rem_fix     = neg_rem_q ? (32'd0 - rem_n) : rem_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (acc_mul) begin
          state_d = ST_MUL;
        end else if (acc_div) begin
          state_d = div_zero ? ST_DONE : ST_DIV;
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (mul_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DIV: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (div_last) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stall = acc_mul || acc_div || (state_q == ST_MUL) || (state_q == ST_DIV);
    done  = (state_q == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      rem_q     <= '0;
      signed_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (acc_mul) begin
            op_a_q   <= srca;
            op_b_q   <= srcb;
            signed_q <= (alucontrol == MULT_CONTROL);
            cnt_q    <= '0;
          end
          if (acc_div) begin
            if (div_zero) begin
              hi_q <= srca;
              lo_q <= 32'hFFFF_FFFF;
            end else begin
              op_a_q    <= mag_a;
              op_b_q    <= mag_b;
              rem_q     <= '0;
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              cnt_q     <= '0;
            end
          end
          if (accept && (alucontrol == MTHI_CONTROL)) begin
            hi_q <= srca;
          end
          if (accept && (alucontrol == MTLO_CONTROL)) begin
            lo_q <= srca;
          end
        end
        ST_MUL: begin
          if (!flush) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (mul_last) begin
              hi_q <= product[63:32];
              lo_q <= product[31:0];
            end
          end
        end
        ST_DIV: begin
          if (!flush) begin
            cnt_q  <= cnt_q + CNT_W'(1);
            op_a_q <= quo_n;
            rem_q  <= rem_n;
            if (div_last) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

  always_comb begin
    hilo_rdata = 32'd0;
    if (alucontrol == MFHI_CONTROL) begin
      hilo_rdata = hi_q;
    end else if (alucontrol == MFLO_CONTROL) begin
      hilo_rdata = lo_q;
    end
  end

endmodule
